// File: rtl/debounce_bank_if.sv
// Raw pin inputs and debounced level/pulse outputs for debounce_bank.
// The master side drives pins and repeat_en; the slave side is the debouncer.
interface debounce_bank_if #(
  parameter int N_BTN = 4,
  parameter int N_SW  = 8
);
  logic [N_BTN-1:0] button;
  logic [N_SW-1:0]  SW;
  logic             repeat_en;
  logic [N_BTN-1:0] button_out;
  logic [N_BTN-1:0] button_pulse;
  logic [N_BTN-1:0] button_release;
  logic [N_BTN-1:0] button_repeat;
  logic [N_SW-1:0]  SW_OK;
  logic [N_SW-1:0]  sw_change;

  modport master (
    output button, SW, repeat_en,
    input  button_out, button_pulse, button_release, button_repeat, SW_OK, sw_change
  );

  modport slave (
    input  button, SW, repeat_en,
    output button_out, button_pulse, button_release, button_repeat, SW_OK, sw_change
  );
endinterface

// File: rtl/debounce_bank.sv
// Per-channel synchroniser + stability counter for buttons and switches, with button auto-repeat.
// New levels appear SYNC_STAGES+STABLE_CYCLES edges after the raw change; all outputs are registered.
module debounce_bank #(
  parameter int N_BTN         = 4,
  parameter int N_SW          = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 100000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic           clk,
  input  logic           rst_n,
  debounce_bank_if.slave io
);
  localparam int N_CH = N_BTN + N_SW;
  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  d;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  ev;
  logic [N_BTN-1:0] rep;

  // Buttons occupy the low channels, switches the high ones.
  assign raw = {io.SW, io.button};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sq;
    logic [CW-1:0]          cnt;
    logic                   dq;
    logic                   rq;
    logic                   fq;
    logic                   s;

    assign s     = sq[SYNC_STAGES-1];
    // The accepting cycle is the last of STABLE_CYCLES consecutive disagreements.
    assign ev[i] = (s != dq) && (cnt == CW'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sq  <= '0;
        cnt <= '0;
        dq  <= 1'b0;
        rq  <= 1'b0;
        fq  <= 1'b0;
      end else begin
        sq <= {sq[SYNC_STAGES-2:0], raw[i]};
        rq <= ev[i] & s;
        fq <= ev[i] & ~s;
        if (s == dq || ev[i]) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        if (ev[i]) begin
          dq <= s;
        end
      end
    end

    assign d[i]    = dq;
    assign rise[i] = rq;
    assign fall[i] = fq;
  end

  for (genvar b = 0; b < N_BTN; b++) begin : g_rep
    logic [HW-1:0] h;
    logic [HW-1:0] h_inc;
    logic [HW-1:0] target;
    logic          armed;
    logic          rq;

    assign h_inc  = h + HW'(1);
    // First interval after the press is HOLD_CYCLES, every later one REPEAT_CYCLES.
    assign target = armed ? HW'(REPEAT_CYCLES) : HW'(HOLD_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        h     <= '0;
        armed <= 1'b0;
        rq    <= 1'b0;
      end else if (!io.repeat_en || !d[b] || ev[b]) begin
        // Released, disabled, or a level change this cycle: no repeat, restart the hold.
        h     <= '0;
        armed <= 1'b0;
        rq    <= 1'b0;
      end else if (h_inc == target) begin
        h     <= '0;
        armed <= 1'b1;
        rq    <= 1'b1;
      end else begin
        h     <= h_inc;
        rq    <= 1'b0;
      end
    end

    assign rep[b] = rq;
  end

  assign io.button_out     = d[N_BTN-1:0];
  assign io.button_pulse   = rise[N_BTN-1:0];
  assign io.button_release = fall[N_BTN-1:0];
  assign io.button_repeat  = rep;
  assign io.SW_OK          = d[N_CH-1:N_BTN];
  assign io.sw_change      = rise[N_CH-1:N_BTN] | fall[N_CH-1:N_BTN];
endmodule
